rtc_bus_responder: RTL
======================

# rtc_bus_responder

Synthesizable responder for the parallel RTC control bus (ChipSelect, Read, Write, AoD, 8-bit data) driven by the function generator. It holds an addressable 8-bit register file. An address-phase write selects the register; data-phase writes and reads access it. It stands in for the RTC chip on the FPGA, giving closed-loop simulation and board bring-up of the bus generator and controller.

## Interface
- DEPTH, 64: number of 8-bit registers. Valid addresses are 0..DEPTH-1. DEPTH ≤ 256, power of two.
- RESET_VAL, 8'h00: reset contents of every register.
- clk  in  1  system clock; every register is clocked on its rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- ChipSelect  in  1  chip select, active-low.
- Read  in  1  read strobe, active-low.
- Write  in  1  write strobe, active-low.
- AoD  in  1  phase select: 0 = address phase, 1 = data phase.
- data_in  in  8  bus value from the initiator; meaningful while Write is low.
- data_out  out  8  value the responder drives on the bus.
- data_oe  out  1  responder drive enable for the top-level tristate buffer.
- addr_q  out  8  currently latched address, for debug.
- err_count  out  8  saturating count of protocol errors.

## Operation
- Bus inputs are registered once per clk as cs_q, rd_q, wr_q, aod_q, din_q. All decisions use these registered copies and their previous-cycle values.
- FSM states:
  - IDLE: cs_q high.
  - SEL: cs_q low, no strobe.
  - WR_ADDR, WR_DATA: cs_q low, wr_q low, with aod_q low or high respectively.
  - RD: cs_q low, rd_q low.
  - ERR: rd_q and wr_q both low with cs_q low.
- The next state is decoded directly from the sampled inputs every cycle. Any state can go to any other.
- Write commit happens on the cycle the FSM leaves WR_ADDR or WR_DATA because wr_q rose, with cs_q still low. It uses din_q captured in the last cycle wr_q was low.
  - WR_ADDR commit: addr_q <= din.
  - WR_DATA commit: if addr_q < DEPTH then mem[addr_q] <= din; otherwise the write is discarded.
- Leaving a write state because cs_q rose before wr_q rose aborts the write: no commit.
- RD with aod_q high: data_out = mem[addr_q], or 8'h00 if addr_q ≥ DEPTH.
- RD with aod_q low: data_out = addr_q (address readback).
- data_oe is high only in RD. It is low in every other state, including ERR.
- ERR: no commit, no drive. err_count increments once on entry to ERR and saturates at 8'hFF.
- A Read or Write strobe low while cs_q is high is ignored. It is not counted as an error.
- addr_q persists across chip-select cycles. Consecutive data accesses reuse it; there is no auto-increment.

## Timing
- Reset values:
  - data_out = 8'h00, data_oe = 0, addr_q = 8'h00, err_count = 8'h00.
  - FSM in IDLE; all sampled inputs at their idle values (high).
  - All mem entries = RESET_VAL.
- Reset asserted mid-transaction clears everything immediately. The pending write is lost.
- Read latency: data_oe and data_out become valid on the 2nd clk edge after Read falls (one sample cycle plus one state cycle). data_oe drops on the 2nd edge after Read or ChipSelect rises.
- Write latency: mem/addr_q update on the 2nd clk edge after Write rises.
- Minimum strobe width: 2 clk low and 2 clk high. Shorter pulses can be missed and no behaviour is guaranteed for them.
- AoD must be stable from Write falling until 2 clk after Write rises. The commit uses the aod_q value held in the write state.
- Read of a register in the same chip-select window as its write returns the new value once the commit edge has passed.

## Test plan
- Address write: CS low; AoD=0; Write low 4 clk with data_in=8'h21; Write high. Required: addr_q=8'h21 two edges after the rise; data_oe never high.
- Data write then read: addr 8'h05; write 8'hA7 in data phase; then Read low with AoD=1. Required: data_oe=1 and data_out=8'hA7 two edges after Read falls; both low again two edges after Read rises.
- Out-of-range address: DEPTH=64, addr 8'h50; write 8'h3C, then read. Required: data_out=8'h00; mem[8'h10] keeps its old value.
- Protocol error: CS low with Read and Write low together for 3 clk, repeated 300 times. Required: no drive, no mem change, err_count=8'hFF (saturated).
- Aborted write: Write low with data 8'h99, then ChipSelect rises before Write rises. Required: target register unchanged; addr_q unchanged.
- Reset mid-read: assert reset while data_oe=1. Required: data_oe=0 and data_out=8'h00 immediately; mem all RESET_VAL; addr_q=8'h00 after release.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// Register-file responder for the parallel RTC control bus (ChipSelect/Read/Write/AoD).
// Stands in for the RTC chip: an address-phase write latches addr_q, and data-phase accesses use it.
module rtc_bus_responder #(
    parameter int         DEPTH     = 64,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ChipSelect,
    input  logic       Read,
    input  logic       Write,
    input  logic       AoD,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] addr_q,
    output logic [7:0] err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        WR_ADDR,
        WR_DATA,
        RD,
        ERR
    } state_t;

    state_t     state;
    state_t     next_state;
    logic       cs_q;
    logic       rd_q;
    logic       wr_q;
    logic       aod_q;
    logic [7:0] din_q;
    logic [7:0] wr_data;
    logic [7:0] rd_value;
    logic       in_range;
    logic       commit;
    logic [7:0] mem [DEPTH];

    // Bus inputs are asynchronous to clk; every decision below uses only these sampled copies.
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            aod_q   <= 1'b1;
            din_q   <= 8'hFF;
            wr_data <= 8'h00;
        end else begin
            cs_q  <= ChipSelect;
            rd_q  <= Read;
            wr_q  <= Write;
            aod_q <= AoD;
            din_q <= data_in;
            if (!wr_q) begin
                wr_data <= din_q;
            end
        end
    end

    // NOTE: every path assigns next_state (default first), so no latch is inferred.
    always_comb begin
        next_state = IDLE;
        if (cs_q) begin
            next_state = IDLE;
        end else if (!rd_q && !wr_q) begin
            next_state = ERR;
        end else if (!rd_q) begin
            next_state = RD;
        end else if (!wr_q) begin
            next_state = aod_q ? WR_DATA : WR_ADDR;
        end else begin
            next_state = SEL;
        end
    end

    assign in_range = ({1'b0, addr_q} < 9'(DEPTH));

    always_comb begin
        rd_value = 8'h00;
        if (!aod_q) begin
            rd_value = addr_q;
        end else if (in_range) begin
            rd_value = mem[addr_q[AW-1:0]];
        end
    end

    // A write commits only when the strobe rises while still selected; a chip-select rise aborts it.
    assign commit = ((state == WR_ADDR) || (state == WR_DATA)) && wr_q && !cs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            addr_q    <= 8'h00;
            err_count <= 8'h00;
        end else begin
            state    <= next_state;
            data_oe  <= (next_state == RD);
            data_out <= (next_state == RD) ? rd_value : 8'h00;
            if (commit && (state == WR_ADDR)) begin
                addr_q <= wr_data;
            end
            if ((next_state == ERR) && (state != ERR) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'h01;
            end
        end
    end

    // NOTE: the register file is reset explicitly because the bus master expects known contents
    // after reset; this keeps it in flops rather than block RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (commit && (state == WR_DATA) && in_range) begin
            mem[addr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule
